// File: rtl/systolic_skew_feeder.sv
// Diagonal skew sequencer for the systolic array: lane k of A/B is delayed k cycles,
// with per-lane valid/first tags and a completion pulse once the array has drained.
module systolic_skew_feeder #(
  parameter int SIZE       = 32,
  parameter int I_BITS     = 8,
  parameter int DEPTH_BITS = 8,
  parameter int SEL_BITS   = 3
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_valid,
  input  logic                   i_last,
  input  logic [SEL_BITS-1:0]    i_size_sel,
  input  logic [I_BITS*SIZE-1:0] i_a_full,
  input  logic [I_BITS*SIZE-1:0] i_b_full,
  output logic                   o_ready,
  output logic [I_BITS*SIZE-1:0] o_a_skew,
  output logic [I_BITS*SIZE-1:0] o_b_skew,
  output logic [SIZE-1:0]        o_lane_valid,
  output logic [SIZE-1:0]        o_lane_first,
  output logic [DEPTH_BITS-1:0]  o_k_count,
  output logic                   o_done
);

  // state    | meaning
  // S_IDLE   | waiting for the first vector of a product; latches N on accept
  // S_STREAM | accepting K-vectors, bubbles shift zeros
  // S_DRAIN  | not ready; down-counter runs 2N cycles, o_done on terminal count

  localparam int LOG2  = $clog2(SIZE);
  localparam int CNT_W = LOG2 + 2;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SEL_BITS-1:0]   w_sel_clamp;
  logic [CNT_W-1:0]      w_n_new;
  logic [CNT_W-1:0]      w_n_use;
  logic [CNT_W-1:0]      r_n_act;
  logic [CNT_W-1:0]      r_drain_cnt;
  logic [DEPTH_BITS-1:0] r_k_count;
  logic                  w_accept;
  logic                  w_first;
  logic                  w_load_drain;

  always_comb begin
    if (i_size_sel > SEL_BITS'(LOG2)) w_sel_clamp = SEL_BITS'(LOG2);
    else                              w_sel_clamp = i_size_sel;
  end

  assign w_n_new   = CNT_W'(1) << w_sel_clamp;
  // The size used for lane masking comes straight from the port only on the IDLE accept.
  assign w_n_use   = (r_state == S_IDLE) ? w_n_new : r_n_act;
  assign o_ready   = (r_state != S_DRAIN);
  assign w_accept  = i_valid && o_ready;
  assign o_k_count = r_k_count;

  always_ff @(posedge i_clock) begin
    if (!i_reset) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_first      = 1'b0;
    w_load_drain = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_first = 1'b1;
          if (i_last) begin
            w_load_drain = 1'b1;
            w_state_nxt  = S_DRAIN;
          end else begin
            w_state_nxt  = S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (w_accept && i_last) begin
          w_load_drain = 1'b1;
          w_state_nxt  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (r_drain_cnt == '0) begin
          o_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_n_act     <= '0;
      r_drain_cnt <= '0;
      r_k_count   <= '0;
    end else begin
      if (r_state == S_IDLE && w_accept) begin
        r_n_act   <= w_n_new;
        r_k_count <= DEPTH_BITS'(1);
      end else if (w_accept && r_k_count != '1) begin
        r_k_count <= r_k_count + DEPTH_BITS'(1);
      end
      if (w_load_drain)
        r_drain_cnt <= (w_n_use << 1) - CNT_W'(1);
      else if (r_state == S_DRAIN && r_drain_cnt != '0)
        r_drain_cnt <= r_drain_cnt - CNT_W'(1);
    end
  end

  for (genvar k = 0; k < SIZE; k++) begin : g_lane
    logic              w_lane_on;
    logic [I_BITS-1:0] r_a_dly [0:k];
    logic [I_BITS-1:0] r_b_dly [0:k];
    logic              r_v_dly [0:k];
    logic              r_f_dly [0:k];

    assign w_lane_on = w_accept && (CNT_W'(k) < w_n_use);

    // Stage k is the output register; stages 0..k-1 form the k-cycle skew.
    always_ff @(posedge i_clock) begin
      if (!i_reset) begin
        for (int j = 0; j <= k; j++) begin
          r_a_dly[j] <= '0;
          r_b_dly[j] <= '0;
          r_v_dly[j] <= 1'b0;
          r_f_dly[j] <= 1'b0;
        end
      end else begin
        r_a_dly[0] <= w_lane_on ? i_a_full[I_BITS*k +: I_BITS] : '0;
        r_b_dly[0] <= w_lane_on ? i_b_full[I_BITS*k +: I_BITS] : '0;
        r_v_dly[0] <= w_lane_on;
        r_f_dly[0] <= w_lane_on && w_first;
        for (int j = 1; j <= k; j++) begin
          r_a_dly[j] <= r_a_dly[j-1];
          r_b_dly[j] <= r_b_dly[j-1];
          r_v_dly[j] <= r_v_dly[j-1];
          r_f_dly[j] <= r_f_dly[j-1];
        end
      end
    end

    assign o_a_skew[I_BITS*k +: I_BITS] = r_a_dly[k];
    assign o_b_skew[I_BITS*k +: I_BITS] = r_b_dly[k];
    assign o_lane_valid[k]              = r_v_dly[k];
    assign o_lane_first[k]              = r_f_dly[k];
  end

endmodule
